// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, default sizing
// constants and the parameter legality check used at elaboration.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLK_DIV = 4;

  function automatic bit params_legal(input int data_w, input int clk_div);
    return (data_w >= 1) && (data_w <= 32) && (clk_div >= 2);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: counts CLK_DIV enabled cycles and emits a one-cycle
// tick on the last one; rearm_i restarts the count from zero.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic en_i,
  input  logic rearm_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (rearm_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_shift.sv
// SPI mode-0 master serializer with CS_N framing and a parallel receive word.
// Bit order: SPI_LSB_FIRST_EN defined -> LSB first, otherwise MSB first.
module spi_master_shift
  import spi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N,
  output spi_state_e        STATE_DBG
);

  localparam int BW = $clog2(DATA_W + 1);

  if (!params_legal(DATA_W, CLK_DIV)) begin : g_bad_params
    $error("spi_master_shift: illegal DATA_W=%0d / CLK_DIV=%0d", DATA_W, CLK_DIV);
  end

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              tick, rearm;
  logic [DATA_W-1:0] tx_next, rx_next;
  logic              tx_next_bit, tx_first_bit;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i   (CLK),
    .clr_n_i (CLR_N),
    .en_i    (state_q != ST_IDLE),
    .rearm_i (rearm),
    .tick_o  (tick)
  );

  always_comb begin
`ifdef SPI_LSB_FIRST_EN
    tx_next              = tx_q >> 1;
    tx_next_bit          = tx_next[0];
    tx_first_bit         = TX_DATA[0];
    rx_next              = rx_q >> 1;
    rx_next[DATA_W-1]    = MISO;
`else
    tx_next              = tx_q << 1;
    tx_next_bit          = tx_next[DATA_W-1];
    tx_first_bit         = TX_DATA[DATA_W-1];
    rx_next              = rx_q << 1;
    rx_next[0]           = MISO;
`endif
  end

  // The SETUP terminal tick doubles as the first SCLK rise, so XFER sees the
  // remaining 2*DATA_W-1 toggles and the last fall lands on tick 2*DATA_W.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          tx_d    = TX_DATA;
          rx_d    = '0;
          bit_d   = '0;
          mosi_d  = tx_first_bit;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rx_d    = rx_next;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q == BW'(DATA_W - 1)) begin
              bit_d   = '0;
              state_d = ST_HOLD;
            end else begin
              bit_d  = bit_q + 1'b1;
              tx_d   = tx_next;
              mosi_d = tx_next_bit;
            end
          end else begin
            sclk_d = 1'b1;
            rx_d   = rx_next;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          rx_data_d = rx_q;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rearm = (state_d != state_q);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RX_DATA   = rx_data_q;
  assign SCLK      = sclk_q;
  assign MOSI      = mosi_q;
  assign CS_N      = cs_n_q;
  assign STATE_DBG = state_q;

endmodule
